// File: rtl/load_data_ext_if.sv
// Load-extension bus: memory-side request (word, funct3, offset, valid) and
// the registered write-back result with its status flags.
interface load_data_ext_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] fromMem;
    logic [2:0]        funct3;
    logic [1:0]        addrOff;
    logic              loadValid;
    logic [DATA_W-1:0] dataIn;
    logic              dataValid;
    logic              misaligned;
    logic              illegal;

    modport master (
        output fromMem, funct3, addrOff, loadValid,
        input  dataIn, dataValid, misaligned, illegal
    );

    modport slave (
        input  fromMem, funct3, addrOff, loadValid,
        output dataIn, dataValid, misaligned, illegal
    );
endinterface

// File: rtl/load_data_ext.sv
// Load-data extension: selects byte/halfword/word from the memory read word,
// sign- or zero-extends it, and registers it with valid/misaligned/illegal flags.
module load_data_ext (
    input logic            clk,
    input logic            rst_n,
    load_data_ext_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic [DATA_W-1:0] ext_data;
    logic              mis_c;
    logic              ill_c;

    // Lane selection from the byte offset
    always_comb begin
        byte_sel = bus.fromMem[7:0];
        unique case (bus.addrOff)
            2'd0: byte_sel = bus.fromMem[7:0];
            2'd1: byte_sel = bus.fromMem[15:8];
            2'd2: byte_sel = bus.fromMem[23:16];
            2'd3: byte_sel = bus.fromMem[31:24];
            default: byte_sel = bus.fromMem[7:0];
        endcase
        half_sel = bus.addrOff[1] ? bus.fromMem[31:16] : bus.fromMem[15:0];
    end

    // Extension and fault classification; faulting accesses return zero
    always_comb begin
        ext_data = '0;
        mis_c    = 1'b0;
        ill_c    = 1'b0;
        case (bus.funct3)
            F3_LB:  ext_data = {{(DATA_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            F3_LBU: ext_data = {{(DATA_W-BYTE_W){1'b0}}, byte_sel};
            F3_LH: begin
                if (bus.addrOff[0]) mis_c = 1'b1;
                else ext_data = {{(DATA_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            end
            F3_LHU: begin
                if (bus.addrOff[0]) mis_c = 1'b1;
                else ext_data = {{(DATA_W-HALF_W){1'b0}}, half_sel};
            end
            F3_LW: begin
                if (bus.addrOff != 2'b00) mis_c = 1'b1;
                else ext_data = bus.fromMem;
            end
            default: ill_c = 1'b1;
        endcase
    end

    // Output register; dataIn holds across idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dataIn     <= '0;
            bus.dataValid  <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
        end else if (bus.loadValid) begin
            bus.dataIn     <= ext_data;
            bus.dataValid  <= 1'b1;
            bus.misaligned <= mis_c;
            bus.illegal    <= ill_c;
        end else begin
            bus.dataValid  <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_load_data_ext.sv
// Scoreboard bench for load_data_ext: directed and random loads against a
// shift-and-mask reference model, with a negedge monitor.
module tb_load_data_ext;
    typedef struct packed {
        logic [31:0] data;
        logic        mis;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    load_data_ext_if bus ();

    load_data_ext dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [31:0] last_data = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: arithmetic on the word as an unsigned integer
    function automatic exp_t model(input logic [31:0] fm, input logic [2:0] f3, input logic [1:0] off);
        exp_t        e;
        int unsigned w, k, b, h;
        e = '0;
        w = fm;
        k = off;
        b = (w >> (8 * k)) & 255;
        h = (w >> (16 * (k / 2))) & 65535;
        case (f3)
            3'd0: e.data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: if (k % 2 != 0) e.mis = 1'b1; else e.data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2: if (k != 0) e.mis = 1'b1; else e.data = w;
            3'd4: e.data = b;
            3'd5: if (k % 2 != 0) e.mis = 1'b1; else e.data = h;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [31:0] fm, input logic [2:0] f3, input logic [1:0] off,
                         input logic v, input exp_t e);
        @(posedge clk);
        #1;
        bus.fromMem   = fm;
        bus.funct3    = f3;
        bus.addrOff   = off;
        bus.loadValid = v;
        if (v) exp_q.push_back(e);
    endtask

    task automatic load_exp(input logic [31:0] fm, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] d, input logic mis, input logic ill);
        exp_t e;
        e.data = d;
        e.mis  = mis;
        e.ill  = ill;
        drive(fm, f3, off, 1'b1, e);
    endtask

    task automatic idle(input logic [31:0] fm);
        drive(fm, 3'd0, 2'd0, 1'b0, '0);
    endtask

    // Monitor: pops on every valid result, checks hold behaviour otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_data = '0;
        end else if (bus.dataValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", bus.dataIn, e.data);
                chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                last_data = e.data;
            end
        end else begin
            chk("hold_data", bus.dataIn, last_data);
            chk("idle_flags", 32'({bus.misaligned, bus.illegal}), 32'd0);
        end
    end

    initial begin
        logic [31:0] fm;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        v;
        int          guard;

        bus.fromMem   = '0;
        bus.funct3    = '0;
        bus.addrOff   = '0;
        bus.loadValid = 1'b0;
        #1;
        chk("rst_data", bus.dataIn, 32'd0);
        chk("rst_valid", 32'(bus.dataValid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Positive loads, all encodings
        load_exp(32'h3E7E047F, 3'b000, 2'd0, 32'h0000007F, 1'b0, 1'b0);
        load_exp(32'h3E7E047F, 3'b001, 2'd0, 32'h0000047F, 1'b0, 1'b0);
        load_exp(32'h3E7E047F, 3'b010, 2'd0, 32'h3E7E047F, 1'b0, 1'b0);
        load_exp(32'h3E7E047F, 3'b100, 2'd0, 32'h0000007F, 1'b0, 1'b0);
        load_exp(32'h3E7E047F, 3'b101, 2'd0, 32'h0000047F, 1'b0, 1'b0);
        // Sign extension and lane select
        load_exp(32'h80F0A5C3, 3'b000, 2'd0, 32'hFFFFFFC3, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b000, 2'd1, 32'hFFFFFFA5, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b000, 2'd2, 32'hFFFFFFF0, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b000, 2'd3, 32'hFFFFFF80, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b100, 2'd2, 32'h000000F0, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b001, 2'd2, 32'hFFFF80F0, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b101, 2'd0, 32'h0000A5C3, 1'b0, 1'b0);
        // Misaligned and illegal, illegal taking precedence
        load_exp(32'h80F0A5C3, 3'b010, 2'd1, 32'h0, 1'b1, 1'b0);
        load_exp(32'h80F0A5C3, 3'b001, 2'd3, 32'h0, 1'b1, 1'b0);
        load_exp(32'h80F0A5C3, 3'b000, 2'd3, 32'hFFFFFF80, 1'b0, 1'b0);
        load_exp(32'h80F0A5C3, 3'b011, 2'd1, 32'h0, 1'b0, 1'b1);
        load_exp(32'h80F0A5C3, 3'b110, 2'd0, 32'h0, 1'b0, 1'b1);
        load_exp(32'h80F0A5C3, 3'b111, 2'd2, 32'h0, 1'b0, 1'b1);
        // Hold across idle cycles with changing memory word
        load_exp(32'h12345678, 3'b010, 2'd0, 32'h12345678, 1'b0, 1'b0);
        idle(32'hDEADBEEF);
        idle(32'h00000000);
        idle(32'hFFFFFFFF);

        // Asynchronous reset mid-cycle with a nonzero held result
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data", bus.dataIn, 32'd0);
        chk("async_rst_valid", 32'(bus.dataValid), 32'd0);
        chk("async_rst_flags", 32'({bus.misaligned, bus.illegal}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            fm  = $urandom;
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            v   = ($urandom_range(0, 3) != 0);
            drive(fm, f3, off, v, model(fm, f3, off));
        end
        idle(32'h0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
